// File: rtl/prog_loader.sv
// prog_loader: boot-time loader that writes a framed byte stream into the
// core's 64 KiB byte memory and holds the core in reset until the image is in.
// Optional feature macro: LOADER_CHECKSUM_EN (adds a trailing CSUM byte and an
// 8-bit running sum over ADDR_L..CSUM that must end at 0x00).
module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_HUNT, S_ADDR_L, S_ADDR_H, S_LEN_L, S_LEN_H, S_DATA, S_CSUM, S_FIN, S_ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t FRAME_END = S_CSUM;
  localparam logic   END_READY = 1'b1;
`else
  localparam state_t FRAME_END = S_FIN;
  localparam logic   END_READY = 1'b0;
`endif

  state_t      state_q;
  logic [15:0] addr_q;
  logic [15:0] cnt_q;
  logic [15:0] idle_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_q;
  logic [7:0]  sum_d_c;
`endif

  logic        accept_c;
  logic        timing_c;
  logic        timeout_c;
  logic [15:0] idle_inc_c;
  logic [15:0] len_c;

  // Handshake, idle-timeout detection and assembled length.
  always_comb begin
    accept_c   = in_valid & in_ready;
    timing_c   = (state_q != S_HUNT) && (state_q != S_FIN) && (state_q != S_ERR);
    idle_inc_c = idle_q + 16'd1;
    timeout_c  = timing_c && !accept_c && (TIMEOUT_CYCLES != 16'd0) &&
                 (idle_inc_c == TIMEOUT_CYCLES);
    len_c      = {in_data, cnt_q[7:0]};
`ifdef LOADER_CHECKSUM_EN
    sum_d_c    = sum_q + in_data;
`endif
  end

  // Frame FSM with registered handshake, write port and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_HUNT;
      addr_q    <= 16'd0;
      cnt_q     <= 16'd0;
      idle_q    <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= 8'd0;
`endif
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'd0;
      mem_wdata <= 8'd0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      // Status follows the terminal state one edge later, clear of the last write.
      done      <= done | (state_q == S_FIN);
      cpu_rst_n <= cpu_rst_n | (state_q == S_FIN);
      err       <= err | (state_q == S_ERR);
      idle_q    <= (timing_c && !accept_c) ? idle_inc_c : 16'd0;

      case (state_q)
        S_HUNT: begin
          in_ready <= 1'b1;
          if (accept_c && (in_data == SYNC_BYTE)) begin
            state_q <= S_ADDR_L;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= 8'd0;
`endif
          end
        end
        S_ADDR_L: if (accept_c) begin
          addr_q[7:0] <= in_data;
          state_q     <= S_ADDR_H;
`ifdef LOADER_CHECKSUM_EN
          sum_q       <= sum_d_c;
`endif
        end
        S_ADDR_H: if (accept_c) begin
          addr_q[15:8] <= in_data;
          state_q      <= S_LEN_L;
`ifdef LOADER_CHECKSUM_EN
          sum_q        <= sum_d_c;
`endif
        end
        S_LEN_L: if (accept_c) begin
          cnt_q[7:0] <= in_data;
          state_q    <= S_LEN_H;
`ifdef LOADER_CHECKSUM_EN
          sum_q      <= sum_d_c;
`endif
        end
        S_LEN_H: if (accept_c) begin
          cnt_q <= len_c;
`ifdef LOADER_CHECKSUM_EN
          sum_q <= sum_d_c;
`endif
          if (len_c != 16'd0) begin
            state_q <= S_DATA;
          end else begin
            state_q  <= FRAME_END;
            in_ready <= END_READY;
          end
        end
        S_DATA: if (accept_c) begin
          mem_we    <= 1'b1;
          mem_addr  <= addr_q;
          mem_wdata <= in_data;
          addr_q    <= addr_q + 16'd1;
          cnt_q     <= cnt_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_q     <= sum_d_c;
`endif
          if (cnt_q == 16'd1) begin
            state_q  <= FRAME_END;
            in_ready <= END_READY;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: if (accept_c) begin
          sum_q    <= sum_d_c;
          in_ready <= 1'b0;
          state_q  <= (sum_d_c == 8'd0) ? S_FIN : S_ERR;
        end
`endif
        S_FIN:   in_ready <= 1'b0;
        S_ERR:   in_ready <= 1'b0;
        default: state_q  <= S_HUNT;
      endcase

      // Idle limit reached with no byte this edge: abort the frame.
      if (timeout_c) begin
        state_q  <= S_ERR;
        in_ready <= 1'b0;
        err      <= 1'b1;
        idle_q   <= 16'd0;
      end
    end
  end

endmodule
